// File: rtl/pipeline_pkg.sv
// Shared decode-bus field positions and register-index type for the RV32 pipeline.
// Latency: none (types and constants only).
// Backpressure: n/a.
package pipeline_pkg;

  localparam int REGWRITE  = 7;
  localparam int MEMRE     = 4;
  localparam int ALUOP_LSB = 0;
  localparam int ALUOP_MSB = 3;
  localparam int NREGS     = 32;

  typedef logic [4:0] xreg_t;

  typedef struct packed {
    logic regwrite;
    logic memre;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input logic [7:0] ctrls);
    ctrl_t c;
    c.regwrite = ctrls[REGWRITE];
    c.memre    = ctrls[MEMRE];
    return c;
  endfunction

endpackage

// File: rtl/sb_counter.sv
// Per-register countdown of cycles until an in-flight result is available.
// Latency: arm value visible the cycle after arm; then decrements once per cycle to 0.
// Backpressure: none; counts down unconditionally, arming takes priority over decrement.
module sb_counter #(
  parameter int LAT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic [LAT_W-1:0] lat,
  output logic [LAT_W-1:0] cnt,
  output logic             busy
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (arm) begin
      cnt <= lat;
    end else if (cnt != '0) begin
      cnt <= cnt - LAT_W'(1);
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/issue_scoreboard.sv
// Decode->execute issue gate tracking in-flight register results; RAW/WAW stalls plus perf counters.
// Latency: combinational ready/issue; counters update on the following edge.
// Backpressure: dec_ready drops on hazard, flush or exe_ready low; in-flight counters keep draining.
module issue_scoreboard
  import pipeline_pkg::*;
#(
  parameter int ALU_LAT  = 1,
  parameter int LOAD_LAT = 2,
  parameter int FWD_EN   = 1,
  parameter int LAT_W    = 3,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_valid,
  output logic             dec_ready,
  input  logic [4:0]       dec_rd,
  input  logic [4:0]       dec_rs1,
  input  logic [4:0]       dec_rs2,
  input  logic [7:0]       dec_ctrls,
  input  logic             exe_ready,
  input  logic             flush,
  output logic             issue,
  output logic             stall_raw,
  output logic             stall_waw,
  output logic [31:0]      busy_vec,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] issue_cnt
);

  ctrl_t                        ctrl;
  logic [LAT_W-1:0]             lat_new;
  logic [NREGS-1:0][LAT_W-1:0]  cnt;
  logic [NREGS-1:0]             busy;
  logic                         issue_wr;
  logic                         rs1_ok;
  logic                         rs2_ok;
  logic                         stall_inc;
  logic                         unused_ctrls;

  assign ctrl         = decode_ctrl(dec_ctrls);
  assign unused_ctrls = ^{dec_ctrls[6:5], dec_ctrls[ALUOP_MSB:ALUOP_LSB]};
  assign lat_new      = ctrl.memre ? LAT_W'(LOAD_LAT) : LAT_W'(ALU_LAT);

  // x0 has no tracking; its slot reads as permanently idle.
  assign cnt[0]  = '0;
  assign busy[0] = 1'b0;

  genvar r;
  generate
    for (r = 1; r < NREGS; r++) begin : g_reg
      sb_counter #(
        .LAT_W(LAT_W)
      ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .arm  (issue_wr && (dec_rd == 5'(r))),
        .lat  (lat_new),
        .cnt  (cnt[r]),
        .busy (busy[r])
      );
    end
  endgenerate

  function automatic logic readable(input logic [LAT_W-1:0] c);
    return (c == '0) || ((FWD_EN != 0) && (c == LAT_W'(1)));
  endfunction

  // Hazards use pre-update counters, so add x1,x1,x1 sees x1's older writer.
  always_comb begin
    rs1_ok    = readable(cnt[dec_rs1]);
    rs2_ok    = readable(cnt[dec_rs2]);
    stall_raw = dec_valid && !(rs1_ok && rs2_ok);
    stall_waw = dec_valid && ctrl.regwrite && (dec_rd != '0) && (cnt[dec_rd] > lat_new);
    dec_ready = exe_ready && !flush && !stall_raw && !stall_waw;
    issue     = dec_valid && dec_ready;
    issue_wr  = issue && ctrl.regwrite && (dec_rd != '0);
    stall_inc = dec_valid && !flush && !dec_ready;
  end

  assign busy_vec = busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      issue_cnt <= '0;
    end else begin
      if (stall_inc && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (issue && (issue_cnt != '1)) begin
        issue_cnt <= issue_cnt + CNT_W'(1);
      end
    end
  end

endmodule
